// File: rtl/pe_rn_pkg.sv
// pe_rn shared types, constants and arithmetic helpers.
// Build option: PE_RN_SAT_EN selects clamping arithmetic; without it sums and truncations wrap.
package pe_rn_pkg;

    localparam int unsigned CNT_BW = 4;

    typedef enum logic [1:0] {
        ModeGemm = 2'b00,
        ModeDiv  = 2'b01,
        ModeExp  = 2'b10,
        ModeLog  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Source of the next oreg value
    typedef enum logic [1:0] {
        SelHold,
        SelGemm,
        SelLoad,
        SelStep
    } sel_e;

    // Reduce a full-precision value to a signed w-bit range (clamp or wrap),
    // returned sign-extended so callers slice the low w bits.
    function automatic logic signed [63:0] sat_fn(input logic signed [63:0] v,
                                                  input int unsigned       w);
`ifdef PE_RN_SAT_EN
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end
        return v;
`else
        return (v <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

    // True when sat_fn had to alter the value
    function automatic logic clip_fn(input logic signed [63:0] v, input int unsigned w);
        return sat_fn(v, w) != v;
    endfunction

    // Drop the fraction bits of an accumulator value and fit it to a multiplier operand
    function automatic logic signed [63:0] trunc_fn(input logic signed [63:0] a,
                                                    input int unsigned       fra,
                                                    input int unsigned       w);
        return sat_fn(a >>> fra, w);
    endfunction

endpackage

// File: rtl/pe_rn_ctrl.sv
// pe_rn sequencer: IDLE/RUN/DONE FSM, Horner step counter, latched mode and per-mode step count.
module pe_rn_ctrl
    import pe_rn_pkg::*;
#(
    parameter int unsigned ITER_DIV = 4,
    parameter int unsigned ITER_EXP = 6,
    parameter int unsigned ITER_LOG = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] gemm_uno,
    input  logic       start_i,
    output sel_e       sel_o,
    output logic       busy_o,
    output logic       done_o
);

    state_e              r_state;
    state_e              w_state_d;
    mode_e               r_mode;
    logic [CNT_BW-1:0]   r_cnt;
    logic                r_busy;
    logic [CNT_BW-1:0]   w_n;
    logic                w_last;
    logic                w_start;

    assign w_start = (r_state == StIdle) && start_i && (gemm_uno != ModeGemm);

    // Step count for the latched mode
    always_comb begin
        w_n = CNT_BW'(ITER_DIV);
        case (r_mode)
            ModeExp: w_n = CNT_BW'(ITER_EXP);
            ModeLog: w_n = CNT_BW'(ITER_LOG);
            default: w_n = CNT_BW'(ITER_DIV);
        endcase
    end

    assign w_last = (r_cnt == (w_n - CNT_BW'(1)));

    // State register with mode latch, step counter and busy flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_mode  <= ModeGemm;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            // busy trails RUN by one edge so it covers the N update edges
            r_busy  <= (r_state == StRun);
            if (w_start) begin
                r_mode <= mode_e'(gemm_uno);
                r_cnt  <= '0;
            end else if (r_state == StRun) begin
                r_cnt <= r_cnt + CNT_BW'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_start) w_state_d = StRun;
            StRun:   if (w_last) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Datapath select and completion pulse
    always_comb begin
        sel_o  = SelHold;
        done_o = 1'b0;
        case (r_state)
            StIdle: begin
                if (gemm_uno == ModeGemm) begin
                    sel_o = SelGemm;
                end else if (start_i) begin
                    sel_o = SelLoad;
                end
            end
            StRun:   sel_o = SelStep;
            StDone:  done_o = 1'b1;
            default: sel_o = SelHold;
        endcase
    end

    assign busy_o = r_busy;

endmodule

// File: rtl/pe_rn.sv
// pe_rn: systolic GEMM MAC cell that also folds unary Horner evaluation (div/exp/log) in time.
// Build option: PE_RN_SAT_EN enables clamping arithmetic and the sat_o flag (tied 0 otherwise).
module pe_rn
    import pe_rn_pkg::*;
#(
    parameter int unsigned INT_BW   = 5,
    parameter int unsigned FRA_BW   = 7,
    parameter int unsigned MUL_BW   = 16,
    parameter int unsigned ACC_BW   = 32,
    parameter int unsigned ITER_DIV = 4,
    parameter int unsigned ITER_EXP = 6,
    parameter int unsigned ITER_LOG = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        gemm_uno,
    input  logic              start_i,
    input  logic [ACC_BW-1:0] mac_i,
    input  logic [MUL_BW-1:0] x_i,
    input  logic [MUL_BW-1:0] wc_i,
    input  logic [ACC_BW-1:0] o_i,
    output logic [ACC_BW-1:0] mac_o,
    output logic [MUL_BW-1:0] wc_o,
    output logic [ACC_BW-1:0] o_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              sat_o
);

    // An operand must fit the multiplier
    if (INT_BW + FRA_BW > MUL_BW) begin : g_bad_cfg
        $error("pe_rn: INT_BW + FRA_BW exceeds MUL_BW");
    end

    logic [MUL_BW-1:0]          r_wreg;
    logic [MUL_BW-1:0]          r_ireg;
    logic [MUL_BW-1:0]          r_xreg;
    logic [ACC_BW-1:0]          r_oreg;
    logic                       r_sat;

    sel_e                       w_sel;
    logic signed [2*MUL_BW-1:0] w_gemm_prod;
    logic signed [63:0]         w_gemm_sum;
    logic signed [MUL_BW-1:0]   w_ox;
    logic signed [2*MUL_BW-1:0] w_step_prod;
    logic signed [63:0]         w_step_sum;
    logic [MUL_BW-1:0]          w_xload;
    logic                       w_gemm_clip;
    logic                       w_step_clip;
    logic [ACC_BW-1:0]          w_oreg_d;
    logic                       w_sat_d;

    pe_rn_ctrl #(
        .ITER_DIV (ITER_DIV),
        .ITER_EXP (ITER_EXP),
        .ITER_LOG (ITER_LOG)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .gemm_uno (gemm_uno),
        .start_i  (start_i),
        .sel_o    (w_sel),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    assign w_gemm_prod = $signed(r_wreg) * $signed(r_ireg);
    assign w_gemm_sum  = w_gemm_prod + $signed(o_i);

    assign w_ox        = MUL_BW'(trunc_fn(64'($signed(r_oreg)), FRA_BW, MUL_BW));
    assign w_step_prod = w_ox * $signed(r_xreg);
    assign w_step_sum  = w_step_prod + $signed(o_i);

    assign w_xload     = MUL_BW'(trunc_fn(64'($signed(mac_i)), FRA_BW, MUL_BW));

`ifdef PE_RN_SAT_EN
    assign w_gemm_clip = clip_fn(w_gemm_sum, ACC_BW);
    assign w_step_clip = clip_fn(w_step_sum, ACC_BW);
`else
    assign w_gemm_clip = 1'b0;
    assign w_step_clip = 1'b0;
`endif

    // Next oreg / sat flag; both hold unless oreg is written
    always_comb begin
        w_oreg_d = r_oreg;
        w_sat_d  = r_sat;
        unique case (w_sel)
            SelGemm: begin
                w_oreg_d = ACC_BW'(sat_fn(w_gemm_sum, ACC_BW));
                w_sat_d  = w_gemm_clip;
            end
            SelLoad: begin
                w_oreg_d = o_i;
                w_sat_d  = 1'b0;
            end
            SelStep: begin
                w_oreg_d = ACC_BW'(sat_fn(w_step_sum, ACC_BW));
                w_sat_d  = w_step_clip;
            end
            default: begin
                w_oreg_d = r_oreg;
                w_sat_d  = r_sat;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wreg <= '0;
            r_ireg <= '0;
            r_xreg <= '0;
            r_oreg <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_wreg <= wc_i;
            r_ireg <= x_i;
            if (w_sel == SelLoad) begin
                r_xreg <= w_xload;
            end
            r_oreg <= w_oreg_d;
            r_sat  <= w_sat_d;
        end
    end

    assign o_o   = r_oreg;
    assign mac_o = r_oreg;
    assign wc_o  = r_wreg;
    assign sat_o = r_sat;

endmodule

// File: tb/tb_pe_rn.sv
// Self-checking bench for pe_rn: cycle model in plain integer arithmetic plus directed vectors.
module tb_pe_rn;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  gemm_uno = 2'b00;
    logic        start_i = 1'b0;
    logic [31:0] mac_i = '0;
    logic [15:0] x_i = '0;
    logic [15:0] wc_i = '0;
    logic [31:0] o_i = '0;
    logic [31:0] mac_o;
    logic [15:0] wc_o;
    logic [31:0] o_o;
    logic        busy_o;
    logic        done_o;
    logic        sat_o;

    int n_tests = 0;
    int n_fail  = 0;

    pe_rn u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gemm_uno (gemm_uno),
        .start_i  (start_i),
        .mac_i    (mac_i),
        .x_i      (x_i),
        .wc_i     (wc_i),
        .o_i      (o_i),
        .mac_o    (mac_o),
        .wc_o     (wc_o),
        .o_o      (o_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .sat_o    (sat_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sx32(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sx16(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    // Fit a value to a signed w-bit range
    function automatic longint fit(input longint v, input int w);
        longint hi;
        longint lo;
        longint m;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
`ifdef PE_RN_SAT_EN
        m = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
        m = v & ((longint'(1) <<< w) - 1);
        if (m > hi) m = m - (longint'(1) <<< w);
`endif
        return m;
    endfunction

    function automatic longint clipped(input longint v, input int w);
`ifdef PE_RN_SAT_EN
        return (fit(v, w) != v) ? 1 : 0;
`else
        return (w > 0 && v == v) ? 0 : 0;
`endif
    endfunction

    function automatic longint tr(input longint a);
        return fit(a >>> 7, 16);
    endfunction

    function automatic int steps(input logic [1:0] m);
        case (m)
            2'b01:   return 4;
            2'b10:   return 6;
            default: return 5;
        endcase
    endfunction

    // Behavioural model: remaining-step count instead of FSM states
    longint m_w = 0, m_i = 0, m_x = 0, m_o = 0;
    longint m_sat = 0, m_busy = 0, m_done = 0;
    int     m_left = 0;
    bit     m_valid = 1'b0;

    always @(posedge clk) begin : model
        longint sum;
        longint no, nsat, nx, ndone;
        int     nleft;
        if (!rst_n) begin
            m_w = 0; m_i = 0; m_x = 0; m_o = 0;
            m_sat = 0; m_busy = 0; m_done = 0; m_left = 0;
        end else begin
            no = m_o; nsat = m_sat; nx = m_x; ndone = 0; nleft = m_left;
            if (m_left > 0) begin
                sum   = tr(m_o) * m_x + sx32(o_i);
                no    = fit(sum, 32);
                nsat  = clipped(sum, 32);
                nleft = m_left - 1;
                ndone = (nleft == 0) ? 1 : 0;
            end else if (m_done != 0) begin
                ndone = 0;
            end else if (gemm_uno == 2'b00) begin
                sum  = m_w * m_i + sx32(o_i);
                no   = fit(sum, 32);
                nsat = clipped(sum, 32);
            end else if (start_i) begin
                nx    = tr(sx32(mac_i));
                no    = sx32(o_i);
                nsat  = 0;
                nleft = steps(gemm_uno);
            end
            m_busy = (m_left > 0) ? 1 : 0;
            m_o = no; m_sat = nsat; m_x = nx; m_done = ndone; m_left = nleft;
            m_w = sx16(wc_i);
            m_i = sx16(x_i);
        end
        m_valid = 1'b1;
    end

    // Compare every cycle once the first edge has happened
    always @(negedge clk) begin
        if (m_valid) begin
            check("o_o",    sx32(o_o),   m_o);
            check("mac_o",  sx32(mac_o), m_o);
            check("wc_o",   sx16(wc_o),  m_w);
            check("busy_o", longint'(busy_o), m_busy);
            check("done_o", longint'(done_o), m_done);
            check("sat_o",  longint'(sat_o),  m_sat);
        end
    end

    longint div_exp [4] = '{24576, 28672, 30720, 31744};
    longint exp_sat_o;
    longint exp_sat_f;
    longint exp_clamp;
    int     seen_done;

    initial begin
`ifdef PE_RN_SAT_EN
        exp_sat_o = 2147483647;
        exp_sat_f = 1;
        exp_clamp = 4194176;
`else
        exp_sat_o = sx32(32'hBFFF0000);
        exp_sat_f = 0;
        exp_clamp = -128;
`endif
        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            gemm_uno = 2'($urandom);
            start_i  = 1'($urandom);
            mac_i    = $urandom;
            x_i      = 16'($urandom);
            wc_i     = 16'($urandom);
            o_i      = $urandom;
            @(negedge clk);
            check("rst_o_o",   sx32(o_o), 0);
            check("rst_busy",  longint'(busy_o), 0);
            check("rst_wc_o",  sx16(wc_o), 0);
            check("rst_done",  longint'(done_o), 0);
        end
        rst_n = 1'b1;

        // GEMM: 2.0 * 3.0 + 1.0
        gemm_uno = 2'b00; start_i = 1'b0; mac_i = '0;
        wc_i = 16'd256; x_i = 16'd384; o_i = 32'd16384;
        @(negedge clk);
        check("gemm_wc_o", sx16(wc_o), 256);
        @(negedge clk);
        check("gemm_o_o", sx32(o_o), 114688);

        // Div Horner, N=4
        gemm_uno = 2'b01; start_i = 1'b1; mac_i = 32'd8192; o_i = 32'd16384;
        @(negedge clk);
        check("div_load", sx32(o_o), 16384);
        check("div_busy0", longint'(busy_o), 0);
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("div_o_o",  sx32(o_o), div_exp[k]);
            check("div_busy", longint'(busy_o), 1);
            check("div_done", longint'(done_o), (k == 3) ? 1 : 0);
        end
        @(negedge clk);
        check("div_done_end", longint'(done_o), 0);
        check("div_busy_end", longint'(busy_o), 0);

        // Saturation / wrap of the GEMM sum
        gemm_uno = 2'b00; wc_i = 16'd32767; x_i = 16'd32767; o_i = 32'h7FFFFFFF;
        @(negedge clk);
        @(negedge clk);
        check("sat_o_o", sx32(o_o), exp_sat_o);
        check("sat_flag", longint'(sat_o), exp_sat_f);
        wc_i = '0; x_i = '0; o_i = '0;
        @(negedge clk);
        check("sat_clear", longint'(sat_o), 0);
        @(negedge clk);
        check("zero_o_o", sx32(o_o), 0);

        // Clamped argument; start/mode changes mid-run are ignored
        gemm_uno = 2'b10; start_i = 1'b1; mac_i = 32'h7FFFFFFF; o_i = 32'd16384;
        @(negedge clk);
        check("clamp_load", sx32(o_o), 16384);
        gemm_uno = 2'b00; o_i = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) check("clamp_step1", sx32(o_o), exp_clamp);
            check("clamp_busy", longint'(busy_o), 1);
            check("clamp_done", longint'(done_o), (k == 6) ? 1 : 0);
        end
        @(negedge clk);
        start_i = 1'b0;
        check("clamp_idle", longint'(busy_o), 0);

        // Reset during RUN aborts without done
        gemm_uno = 2'b11; start_i = 1'b1; mac_i = 32'd8192; o_i = 32'd16384;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check("abort_busy_run", longint'(busy_o), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_o_o",  sx32(o_o), 0);
        check("abort_busy", longint'(busy_o), 0);
        check("abort_done", longint'(done_o), 0);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_o) seen_done++;
        end
        check("abort_no_done", seen_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
